// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages: word width, reset defaults,
// fetch FSM states and a word-alignment helper.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUF  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~WORD_W'(3);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register holding {pc, instr, valid}; flush and reset both load a
// bubble, flush overriding a held (write-disabled) register.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic              flush_i,
  input  logic [WORD_W-1:0] pc_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic              valid_i,
  output logic [WORD_W-1:0] pc_o,
  output logic [WORD_W-1:0] instr_o,
  output logic              valid_o
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] instr_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (reset_i || flush_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (we_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= valid_i;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, one-word skid buffer
// and redirect handling, feeding the IF/ID pipeline register.
//   state | meaning
//   RUN   | request outstanding at PC; an ack delivers, buffers or is dropped
//   BUF   | one acked word parked while the hazard unit holds; no request
//   DROP  | old request still in flight after a redirect; its word is discarded
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              IF_ID_Flush,
  input  logic              Redirect,
  input  logic [WORD_W-1:0] RedirectPC,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] IF_ID_PC,
  output logic [WORD_W-1:0] IF_ID_Instr,
  output logic              IF_ID_Valid,
  output logic              FetchBusy
);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] pend_q, pend_d;
  logic [WORD_W-1:0] buf_pc_q, buf_pc_d;
  logic [WORD_W-1:0] buf_instr_q, buf_instr_d;

  logic              adv;
  logic              ack;
  logic [WORD_W-1:0] target;
  logic              deliver;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_instr;

  assign adv       = PCWrite & IF_ID_Write;
  assign target    = word_align(RedirectPC);
  assign imem_req  = ~reset & (state_q != BUF);
  assign imem_addr = pc_q;
  // Acks are only meaningful against a live request.
  assign ack       = imem_ack & imem_req;
  assign FetchBusy = reset | ~(((state_q == RUN) & imem_ack) | (state_q == BUF));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    deliver     = 1'b0;
    out_pc      = pc_q + 32'd4;
    out_instr   = imem_rdata;

    unique case (state_q)
      RUN: begin
        if (ack) begin
          if (Redirect) begin
            pc_d = target;
          end else if (adv) begin
            deliver = 1'b1;
            pc_d    = pc_q + 32'd4;
          end else begin
            buf_pc_d    = pc_q + 32'd4;
            buf_instr_d = imem_rdata;
            state_d     = BUF;
          end
        end else if (Redirect) begin
          pend_d  = target;
          state_d = DROP;
        end
      end
      BUF: begin
        out_pc    = buf_pc_q;
        out_instr = buf_instr_q;
        if (Redirect) begin
          pc_d    = target;
          state_d = RUN;
        end else if (adv) begin
          deliver = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = RUN;
        end
      end
      DROP: begin
        if (Redirect) pend_d = target;
        if (ack) begin
          pc_d    = Redirect ? target : pend_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      pend_q      <= '0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  // Whenever IF/ID is written without a delivered word, it takes a bubble.
  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .reset_i (reset),
    .we_i    (IF_ID_Write),
    .flush_i (IF_ID_Flush),
    .pc_i    (deliver ? out_pc : '0),
    .instr_i (deliver ? out_instr : NOP_INSTR),
    .valid_i (deliver),
    .pc_o    (IF_ID_PC),
    .instr_o (IF_ID_Instr),
    .valid_o (IF_ID_Valid)
  );

endmodule
